// File: rtl/uart_axi_wslave.sv
// uart_axi_wslave
// ---------------------------------------------------------------------------
// AXI4-Lite write responder for the UART region. Each accepted AW/W pair is
// decoded into at most one byte that is pushed into a transmit FIFO, and the
// transaction completes with a B response. An 8N1 serializer drains the FIFO
// onto uart_tx, one bit every CLK_DIV clock cycles.
//
// Parameters
//   FIFO_DEPTH : transmit FIFO entries (power of two, >= 2)
//   CLK_DIV    : clock cycles per serial bit (>= 2)
//
// Ports
//   clk, rst             : clock (rising edge), asynchronous active-low reset
//   io_slave_aw*         : write address channel (awaddr, awsize, valid/ready)
//   io_slave_w*          : write data channel (wdata, wstrb, valid/ready)
//   io_slave_b*          : write response channel (bresp, valid/ready)
//   uart_tx              : serial line, idles high
//   tx_busy              : FIFO non-empty or serializer active
//
// Configuration
//   UART_SIM_PRINT_EN    : when defined, each committed byte is echoed to the
//                          simulation console with $write (simulation only).
// ---------------------------------------------------------------------------
module uart_axi_wslave #(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_slave_awvalid,
    output logic        io_slave_awready,
    input  logic [31:0] io_slave_awaddr,
    input  logic [2:0]  io_slave_awsize,
    input  logic        io_slave_wvalid,
    output logic        io_slave_wready,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    output logic        io_slave_bvalid,
    input  logic        io_slave_bready,
    output logic [1:0]  io_slave_bresp,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } s_state_e;

    // Byte from the lowest-numbered enabled lane; zero when no lane is set.
    function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [3:0] strb);
        logic [7:0] sel;
        sel = 8'h00;
        if (strb[0]) begin
            sel = data[7:0];
        end else if (strb[1]) begin
            sel = data[15:8];
        end else if (strb[2]) begin
            sel = data[23:16];
        end else if (strb[3]) begin
            sel = data[31:24];
        end else begin
            sel = 8'h00;
        end
        return sel;
    endfunction

    // Write channel state
    w_state_e       w_state_r;
    logic           awready_r;
    logic           wready_r;
    logic           bvalid_r;
    logic [1:0]     bresp_r;
    logic           commit_done_r;
    logic [1:0]     addr_lo_r;
    logic [31:0]    wdata_r;
    logic [3:0]     wstrb_r;

    // FIFO state
    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [CW-1:0]  wr_ptr_r;
    logic [CW-1:0]  rd_ptr_r;

    // Serializer state
    s_state_e       s_state_r;
    logic [BW-1:0]  baud_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shreg_r;
    logic           uart_tx_r;
    logic           tx_busy_r;

    // Combinational helpers
    logic           aw_hs_s;
    logic           w_hs_s;
    logic           commit_s;
    logic           addr_ok_s;
    logic           push_s;
    logic           pop_s;
    logic [7:0]     push_byte_s;
    logic [7:0]     head_s;
    logic [CW-1:0]  fifo_count_s;
    logic [CW-1:0]  count_next_s;
    logic           empty_s;
    logic           full_s;
    logic           full_next_s;
    logic           baud_end_s;
    logic           ser_busy_next_s;
    logic           unused_s;

    // Only the low address bits decide alignment; size is not used for routing.
    assign unused_s = ^{io_slave_awaddr[31:2], io_slave_awsize};

    assign aw_hs_s      = io_slave_awvalid && awready_r;
    assign w_hs_s       = io_slave_wvalid && wready_r;
    assign commit_s     = (w_state_r == W_RESP) && !commit_done_r;
    assign addr_ok_s    = (addr_lo_r == 2'b00);
    assign push_byte_s  = lane_byte(wdata_r, wstrb_r);
    assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
    assign fifo_count_s = wr_ptr_r - rd_ptr_r;
    assign empty_s      = (fifo_count_s == {CW{1'b0}});
    assign full_s       = (fifo_count_s == DEPTH_CNT);
    assign baud_end_s   = (baud_r == BAUD_LAST);

    // The serializer takes the head either from idle or at the end of a stop bit.
    assign pop_s  = !empty_s && ((s_state_r == S_IDLE) || ((s_state_r == S_STOP) && baud_end_s));
    // Acceptance is gated on space, so a commit always finds room; the pop term
    // keeps a simultaneous push/pop on a full FIFO legal.
    assign push_s = commit_s && addr_ok_s && (wstrb_r != 4'b0000) && (!full_s || pop_s);

    assign count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
    assign full_next_s  = (count_next_s == DEPTH_CNT);

    // Serializer is active next cycle unless it is finishing a stop bit with nothing queued.
    assign ser_busy_next_s = pop_s ||
                             ((s_state_r != S_IDLE) && !((s_state_r == S_STOP) && baud_end_s));

    assign io_slave_awready = awready_r;
    assign io_slave_wready  = wready_r;
    assign io_slave_bvalid  = bvalid_r;
    assign io_slave_bresp   = bresp_r;
    assign uart_tx          = uart_tx_r;
    assign tx_busy          = tx_busy_r;

    // Write channel FSM: capture AW/W, commit once both are held, then hold the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_r     <= W_IDLE;
            awready_r     <= 1'b0;
            wready_r      <= 1'b0;
            bvalid_r      <= 1'b0;
            bresp_r       <= 2'b00;
            commit_done_r <= 1'b0;
            addr_lo_r     <= 2'b00;
            wdata_r       <= 32'h0000_0000;
            wstrb_r       <= 4'b0000;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        addr_lo_r <= io_slave_awaddr[1:0];
                    end
                    if (w_hs_s) begin
                        wdata_r <= io_slave_wdata;
                        wstrb_r <= io_slave_wstrb;
                    end
                    if (aw_hs_s && w_hs_s) begin
                        w_state_r <= W_RESP;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                    end else if (aw_hs_s) begin
                        w_state_r <= W_HAVE_AW;
                        awready_r <= 1'b0;
                        wready_r  <= !full_next_s;
                    end else if (w_hs_s) begin
                        w_state_r <= W_HAVE_W;
                        awready_r <= !full_next_s;
                        wready_r  <= 1'b0;
                    end else begin
                        awready_r <= !full_next_s;
                        wready_r  <= !full_next_s;
                    end
                end
                W_HAVE_AW: begin
                    awready_r <= 1'b0;
                    if (w_hs_s) begin
                        wdata_r   <= io_slave_wdata;
                        wstrb_r   <= io_slave_wstrb;
                        w_state_r <= W_RESP;
                        wready_r  <= 1'b0;
                    end else begin
                        wready_r  <= !full_next_s;
                    end
                end
                W_HAVE_W: begin
                    wready_r <= 1'b0;
                    if (aw_hs_s) begin
                        addr_lo_r <= io_slave_awaddr[1:0];
                        w_state_r <= W_RESP;
                        awready_r <= 1'b0;
                    end else begin
                        awready_r <= !full_next_s;
                    end
                end
                W_RESP: begin
                    if (commit_s) begin
                        commit_done_r <= 1'b1;
                        bvalid_r      <= 1'b1;
                        bresp_r       <= addr_ok_s ? 2'b00 : 2'b10;
                        awready_r     <= 1'b0;
                        wready_r      <= 1'b0;
`ifdef UART_SIM_PRINT_EN
                        if (push_s) begin
                            $write("%c", push_byte_s);
                        end
`endif
                    end else if (bvalid_r && io_slave_bready) begin
                        bvalid_r      <= 1'b0;
                        commit_done_r <= 1'b0;
                        w_state_r     <= W_IDLE;
                        awready_r     <= !full_next_s;
                        wready_r      <= !full_next_s;
                    end else begin
                        awready_r     <= 1'b0;
                        wready_r      <= 1'b0;
                    end
                end
                default: begin
                    w_state_r     <= W_IDLE;
                    awready_r     <= 1'b0;
                    wready_r      <= 1'b0;
                    bvalid_r      <= 1'b0;
                    commit_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Transmit FIFO storage and pointers (extra pointer bit distinguishes full from empty).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {CW{1'b0}};
            rd_ptr_r <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_byte_s;
                wr_ptr_r                <= wr_ptr_r + CW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + CW'(1);
            end
        end
    end

    // 8N1 serializer; uart_tx is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_state_r <= S_IDLE;
            baud_r    <= {BW{1'b0}};
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            uart_tx_r <= 1'b1;
            tx_busy_r <= 1'b0;
        end else begin
            tx_busy_r <= ser_busy_next_s || (count_next_s != {CW{1'b0}});
            case (s_state_r)
                S_IDLE: begin
                    uart_tx_r <= 1'b1;
                    baud_r    <= {BW{1'b0}};
                    if (pop_s) begin
                        shreg_r   <= head_s;
                        s_state_r <= S_START;
                    end
                end
                S_START: begin
                    uart_tx_r <= 1'b0;
                    if (baud_end_s) begin
                        baud_r    <= {BW{1'b0}};
                        bit_idx_r <= 3'd0;
                        s_state_r <= S_DATA;
                    end else begin
                        baud_r    <= baud_r + BW'(1);
                    end
                end
                S_DATA: begin
                    uart_tx_r <= shreg_r[0];
                    if (baud_end_s) begin
                        baud_r  <= {BW{1'b0}};
                        shreg_r <= {1'b0, shreg_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            s_state_r <= S_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                S_STOP: begin
                    uart_tx_r <= 1'b1;
                    if (baud_end_s) begin
                        baud_r <= {BW{1'b0}};
                        if (pop_s) begin
                            shreg_r   <= head_s;
                            s_state_r <= S_START;
                        end else begin
                            s_state_r <= S_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + BW'(1);
                    end
                end
                default: begin
                    s_state_r <= S_IDLE;
                    uart_tx_r <= 1'b1;
                    baud_r    <= {BW{1'b0}};
                end
            endcase
        end
    end

endmodule
